subbytes_seq: RTL



---
 rtl/subbytes_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/subbytes_seq.sv
// subbytes_seq: multi-cycle AES SubBytes / InvSubBytes engine with bypass.
// LANES S-box lanes walk the 16 state bytes MSB-first under valid/ready flow.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = TAB[a];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    assign y = TAB[a];
endmodule

module subbytes_seq #(
    parameter int LANES   = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ip,
    input  logic         enable,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] op,
    output logic         busy
);
    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [127:0] op_q, op_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         inv_q, inv_d;
    logic [3:0]   base;
    logic [4:0]   cnt_nxt;
    logic [7:0]   work_b   [16];
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

    assign base    = cnt_q[3:0];
    assign cnt_nxt = cnt_q + 5'(LANES);

    for (genvar i = 0; i < 16; i++) begin : g_bytes
        assign work_b[i] = work_q[127-8*i -: 8];
    end

    // lane l handles byte cnt+l; the mux uses the flag latched at accept
    for (genvar l = 0; l < LANES; l++) begin : g_lanes
        logic [7:0] fwd;
        logic [7:0] rev;
        assign lane_in[l] = work_b[base + 4'(l)];
        aes_sbox     u_fwd (.a(lane_in[l]), .y(fwd));
        aes_inv_sbox u_inv (.a(lane_in[l]), .y(rev));
        assign lane_out[l] = inv_q ? rev : fwd;
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = ip;
                    inv_d  = inv;
                    cnt_d  = '0;
                    if (enable) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        op_d    = ip;
                    end
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[8*(15-int'(base)-l) +: 8] = lane_out[l];
                end
                cnt_d = cnt_nxt;
                if (cnt_nxt == 5'd16) begin
                    state_d = DONE;
                    op_d    = work_d;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);

    if (REG_OUT) begin : g_op_reg
        assign op = op_q;
    end else begin : g_op_comb
        assign op = work_q;
    end
endmodule
